tx_frame_packetizer: RTL and testbench
======================================

TX_FRAME_PACKETIZER -- requirements
Module: tx_frame_packetizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: payload byte buffer depth, power of two.
REQ-002 SHALL have parameter LEN_WIDTH, default 17: payload length field width, covering 320*240 = 76800.
REQ-003 SHALL have parameters SYNC_BYTE, default 8'hA5, and TRAIL_BYTE, default 8'h5A: frame delimiters.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: one-cycle frame-begin pulse.
REQ-007 SHALL have port frame_length, input, LEN_WIDTH: payload byte count, sampled on an accepted start.
REQ-008 SHALL have port in_data, input, 8: payload byte from the filter stage.
REQ-009 SHALL have port in_valid, input, 1: in_data valid.
REQ-010 SHALL have port in_ready, output, 1: byte accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port UART_ready, input, 1: transmitter idle.
REQ-012 SHALL have port UART_data, output, 8: byte to the transmitter.
REQ-013 SHALL have port UART_is_new, output, 1: one-cycle send strobe.
REQ-014 SHALL have port busy, output, 1: frame in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the trailer byte is issued.

Function
REQ-016 SHALL emit frames in this order: SYNC; length bytes {7'b0,len[16]}, len[15:8], len[7:0]; payload bytes in arrival order; checksum; TRAIL.
REQ-017 SHALL compute checksum as the 8-bit sum of all payload bytes, mod 256; length 0 yields checksum 8'h00.
REQ-018 SHALL implement states IDLE -> HDR (4 bytes) -> PAYLOAD -> CKSUM -> TRAIL -> IDLE; with length 0, HDR goes directly to CKSUM.
REQ-019 SHALL, in IDLE, accept start only when busy is low; start while busy SHALL be ignored, with no effect on the frame in progress.
REQ-020 SHALL set busy the cycle after an accepted start and clear it the same cycle done pulses.
REQ-021 SHALL drive in_ready high only when all of these hold: busy, FIFO not full, and accepted byte count < latched length.
REQ-022 SHALL let payload bytes enter the FIFO during HDR, so the filter is not stalled by header transmission.
REQ-023 SHALL pulse UART_is_new for exactly one cycle, with UART_data stable that cycle, only when UART_ready is high and a byte is pending.
REQ-024 SHALL NOT issue the next UART_is_new until UART_ready has been sampled low at least once after the previous pulse.
REQ-025 SHALL, in PAYLOAD with the FIFO empty, issue no strobe and wait without timeout.
REQ-026 SHALL allow a simultaneous FIFO write and read in one cycle, including at full and at empty.
REQ-027 SHALL take the first strobe no earlier than 1 cycle after start.
REQ-028 SHALL make the payload count and byte counters wrap-free: width LEN_WIDTH, compared against the latched length.
REQ-029 SHALL leave in_valid bytes beyond the latched length unaccepted, with in_ready low.

Reset
REQ-030 SHALL, on rst low, immediately force state IDLE, clear the FIFO, set UART_is_new=0, busy=0, done=0, in_ready=0, UART_data=8'h00, and zero the checksum and counters.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no trailer and output no further bytes; the next start begins a fresh frame.

Structure
REQ-032 SHALL place the state encoding, SYNC_BYTE/TRAIL_BYTE defaults and length-byte count in shared package tx_frame_pkg.
REQ-033 SHALL implement the buffer as sub-module byte_fifo (synchronous, FIFO_DEPTH entries, full/empty flags, first-word read registered).

Verification
REQ-034 SHALL cover: length=3, payload 8'h01,8'h02,8'h03, UART_ready toggling -> bytes A5,00,00,03,01,02,03,06,5A, then one done pulse.
REQ-035 SHALL cover: length=0 -> A5,00,00,00,00,5A; in_ready never high.
REQ-036 SHALL cover: length=76800, all bytes 8'hFF, in_valid constant -> length bytes 01,2C,00; checksum 8'h00; in_ready deasserts at full and never overflows.
REQ-037 SHALL cover: start pulsed again mid-payload with a different length -> ignored; original frame bit-exact.
REQ-038 SHALL cover: rst asserted after 2 payload bytes -> all outputs zero same cycle; a following length=1 frame with 8'h7E -> A5,00,00,01,7E,7E,5A.
REQ-039 SHALL cover: UART_ready held high 10 cycles after a strobe -> no second strobe until UART_ready has dropped once.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// Shared definitions for the TX frame packetizer: FSM encoding, delimiter
// defaults and header layout.
package tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_TRAIL
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
  localparam logic [7:0] TRAIL_DEFAULT = 8'h5A;

  // Header = SYNC followed by the big-endian length bytes.
  localparam int LEN_BYTES = 3;
  localparam int HDR_BYTES = LEN_BYTES + 1;

  // Length byte for header slot idx (1 = most significant).
  function automatic logic [7:0] len_byte(input logic [8*LEN_BYTES-1:0] len,
                                          input logic [1:0] idx);
    return 8'(len >> (8 * (LEN_BYTES - int'(idx))));
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered read data (one-cycle read latency)
// and full/empty flags; pointers clear on reset.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A write at full is legal when the same cycle frees a slot.
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
    if (rd_ok) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_frame_packetizer.sv
// Wraps a payload stream into SYNC / length / payload / checksum / TRAIL
// frames and feeds them byte-by-byte to a ready/strobe UART transmitter.
module tx_frame_packetizer
  import tx_frame_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         LEN_WIDTH  = 17,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
  parameter logic [7:0] TRAIL_BYTE = TRAIL_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_length,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 UART_ready,
  output logic [7:0]           UART_data,
  output logic                 UART_is_new,
  output logic                 busy,
  output logic                 done
);

  localparam int         LEN_EXT_W = 8 * LEN_BYTES;
  localparam logic [1:0] HDR_LAST  = 2'(HDR_BYTES - 1);

  state_t               state;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] acc_cnt;
  logic [LEN_WIDTH-1:0] sent_cnt;
  logic [7:0]           cksum;
  logic [7:0]           pend_byte;
  logic                 pend_valid;
  logic                 rd_inflight;
  logic                 ready_seen_low;
  logic                 trail_sent;
  logic [1:0]           hdr_idx;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [7:0]           fifo_rd_data;
  logic                 wr_fire;
  logic                 can_send;
  logic [7:0]           hdr_byte;

  assign in_ready = busy && !fifo_full && (acc_cnt < len_reg);
  assign wr_fire  = in_valid && in_ready;
  // Keep one payload byte staged ahead so FIFO read latency never stalls a send.
  assign fifo_rd_en = busy && !fifo_empty && !pend_valid && !rd_inflight;
  assign can_send   = UART_ready && ready_seen_low && !UART_is_new;
  assign hdr_byte   = (hdr_idx == 2'd0) ? SYNC_BYTE
                                        : len_byte(LEN_EXT_W'(len_reg), hdr_idx);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_data (in_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      len_reg        <= '0;
      acc_cnt        <= '0;
      sent_cnt       <= '0;
      cksum          <= 8'h00;
      pend_byte      <= 8'h00;
      pend_valid     <= 1'b0;
      rd_inflight    <= 1'b0;
      ready_seen_low <= 1'b1;
      trail_sent     <= 1'b0;
      hdr_idx        <= 2'd0;
      UART_data      <= 8'h00;
      UART_is_new    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      UART_is_new <= 1'b0;
      done        <= 1'b0;
      // The strobe cycle itself does not count as the UART going busy.
      if (!UART_ready && !UART_is_new) ready_seen_low <= 1'b1;
      if (wr_fire) acc_cnt <= acc_cnt + 1'b1;
      rd_inflight <= fifo_rd_en;
      if (rd_inflight) begin
        pend_byte  <= fifo_rd_data;
        pend_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start && !busy) begin
            len_reg  <= frame_length;
            acc_cnt  <= '0;
            sent_cnt <= '0;
            cksum    <= 8'h00;
            hdr_idx  <= 2'd0;
            busy     <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (can_send) begin
            UART_data      <= hdr_byte;
            UART_is_new    <= 1'b1;
            ready_seen_low <= 1'b0;
            hdr_idx        <= hdr_idx + 2'd1;
            if (hdr_idx == HDR_LAST)
              state <= (len_reg == '0) ? ST_CKSUM : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (can_send && pend_valid) begin
            UART_data      <= pend_byte;
            UART_is_new    <= 1'b1;
            ready_seen_low <= 1'b0;
            pend_valid     <= 1'b0;
            cksum          <= cksum + pend_byte;
            sent_cnt       <= sent_cnt + 1'b1;
            if (sent_cnt == len_reg - 1'b1) state <= ST_CKSUM;
          end
        end
        ST_CKSUM: begin
          if (can_send) begin
            UART_data      <= cksum;
            UART_is_new    <= 1'b1;
            ready_seen_low <= 1'b0;
            state          <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (trail_sent) begin
            trail_sent <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (can_send) begin
            UART_data      <= TRAIL_BYTE;
            UART_is_new    <= 1'b1;
            ready_seen_low <= 1'b0;
            trail_sent     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_packetizer.sv
// Directed bench for tx_frame_packetizer: drives payload and a simple UART
// model, and compares every emitted frame against hand-written byte lists.
module tb_tx_frame_packetizer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] frame_length;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        UART_ready;
  logic [7:0]  UART_data;
  logic        UART_is_new;
  logic        busy;
  logic        done;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  bq_t got;
  bq_t pay;
  int  feed_idx = 0;
  int  fires = 0;
  bit  feed_en = 0;
  bit  fire_prev;
  bit  ir_seen;
  bit  bp_seen;

  int  uart_gap = 2;
  int  gap_left;
  bit  uart_hold = 0;
  bit  kick = 0;
  bit  prev_new;
  int  done_cnt = 0;
  int  d0;
  int  first_cyc;
  int  start_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_frame_packetizer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_length (frame_length),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .UART_ready   (UART_ready),
    .UART_data    (UART_data),
    .UART_is_new  (UART_is_new),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Payload source: a byte offered at one negedge is taken at the next posedge
  // when in_ready is high, so the index advances one negedge later.
  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    fire_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fire_prev) begin
        feed_idx++;
        fires++;
      end
      if (feed_en && feed_idx < pay.size()) begin
        in_valid = 1'b1;
        in_data  = pay[feed_idx];
      end else begin
        in_valid = 1'b0;
      end
      fire_prev = in_valid && in_ready && rst;
      if (in_ready) ir_seen = 1'b1;
      if (busy && in_valid && !in_ready) bp_seen = 1'b1;
    end
  end

  // UART model: captures each strobe, then goes not-ready for uart_gap cycles
  // (needs uart_gap >= 2 so a low level is seen after the strobe cycle).
  initial begin
    UART_ready = 1'b1;
    gap_left   = 0;
    prev_new   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        UART_ready = 1'b1;
        gap_left   = 0;
      end else if (UART_is_new) begin
        check("strobe_single_cycle", prev_new, 0);
        got.push_back(UART_data);
        if (got.size() == 1) first_cyc = cyc;
        if (!uart_hold) begin
          UART_ready = 1'b0;
          gap_left   = uart_gap;
        end
      end else if (kick) begin
        kick       = 1'b0;
        UART_ready = 1'b0;
        gap_left   = uart_gap;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) UART_ready = 1'b1;
      end
      prev_new = UART_is_new;
      if (done) begin
        done_cnt++;
        check("busy_clear_with_done", busy, 0);
      end
    end
  end

  task automatic compare_stream(input string tag, input bq_t exp, input bit exact);
    if (exact) check({tag, "_count"}, got.size(), exp.size());
    else       check({tag, "_enough"}, got.size() >= exp.size(), 1);
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic begin_frame(input logic [16:0] len, input bq_t p, input int gap);
    feed_en = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    pay      = p;
    feed_idx = 0;
    fires    = 0;
    got.delete();
    ir_seen   = 1'b0;
    bp_seen   = 1'b0;
    uart_gap  = gap;
    d0        = done_cnt;
    first_cyc = -1;
    frame_length = len;
    start     = 1'b1;
    start_cyc = cyc;
    feed_en   = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    frame_length = '1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_frame(input string tag, input bq_t exp, input int restart_at,
                              input int exp_fires);
    bit restarted = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt != d0) break;
      if (restart_at >= 0 && !restarted && got.size() >= restart_at) begin
        start        = 1'b1;
        frame_length = 17'd2;
        restarted    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    repeat (5) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_first_strobe_late"}, (first_cyc - start_cyc) >= 1, 1);
    check({tag, "_accepted"}, fires, exp_fires);
    compare_stream(tag, exp, 1'b1);
    $display("frame %s: bytes_out=%0d accepted=%0d", tag, got.size(), fires);
  endtask

  task automatic apply_reset(input string tag);
    #2 rst = 1'b0;
    #1 check(tag, {UART_is_new, busy, done, in_ready, UART_data}, 12'h000);
    feed_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bq_t e;
    bq_t p;
    int  n;
    rst = 1'b0;
    start = 1'b0;
    frame_length = '0;
    #1 check("reset_outputs", {UART_is_new, busy, done, in_ready, UART_data}, 12'h000);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Length 3 with two extra bytes offered beyond the length.
    p = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB};
    e = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06, 8'h5A};
    begin_frame(17'd3, p, 2);
    finish_frame("len3", e, -1, 3);

    // Empty payload.
    p.delete();
    e = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
    begin_frame(17'd0, p, 2);
    finish_frame("len0", e, -1, 0);
    check("len0_in_ready_never", ir_seen, 0);

    // UART_ready stays high after a strobe: no second strobe until it drops.
    uart_hold = 1'b1;
    begin_frame(17'd0, p, 2);
    for (int i = 0; i < 50 && got.size() < 1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("hold_single_strobe", got.size(), 1);
    uart_hold = 1'b0;
    kick      = 1'b1;
    finish_frame("hold", e, -1, 0);

    // Start pulsed mid-payload with another length: ignored.
    p = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    e = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'hF0, 8'h5A};
    begin_frame(17'd5, p, 2);
    finish_frame("restart", e, 6, 5);

    // 256 x FF with a slow UART: FIFO fills, checksum wraps to 00.
    p.delete();
    e = '{8'hA5, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      p.push_back(8'hFF);
      e.push_back(8'hFF);
    end
    e.push_back(8'h00);
    e.push_back(8'h5A);
    begin_frame(17'd256, p, 6);
    finish_frame("ff256", e, -1, 256);
    check("ff256_backpressure", bp_seen, 1);

    // Maximum length 76800: header bytes and backpressure, then abandon by reset.
    p.delete();
    for (int i = 0; i < 40; i++) p.push_back(8'hFF);
    e = '{8'hA5, 8'h01, 8'h2C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    begin_frame(17'd76800, p, 6);
    for (int i = 0; i < 500 && got.size() < 8; i++) @(negedge clk);
    compare_stream("len76800", e, 1'b0);
    check("len76800_backpressure", bp_seen, 1);
    check("len76800_in_ready_at_full", in_ready, 0);
    apply_reset("len76800_reset_outputs");
    $display("frame len76800: bytes_out=%0d accepted=%0d (aborted)", got.size(), fires);

    // Reset after two payload bytes, then a fresh one-byte frame.
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    e = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22};
    begin_frame(17'd4, p, 2);
    for (int i = 0; i < 500 && got.size() < 6; i++) @(negedge clk);
    apply_reset("midframe_reset_outputs");
    n = got.size();
    repeat (30) @(negedge clk);
    check("no_bytes_after_reset", got.size(), n);
    compare_stream("midframe", e, 1'b1);
    $display("frame midframe: bytes_out=%0d (aborted)", got.size());
    p = '{8'h7E};
    e = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h7E, 8'h5A};
    begin_frame(17'd1, p, 2);
    finish_frame("after_reset", e, -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
